// File: rtl/pipeline_pkg.sv
// pipeline_pkg: instruction field positions, format codes and fetch FSM states
package pipeline_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam int COND_HI = 31;
  localparam int COND_LO = 28;
  localparam int FMT_HI = 27;
  localparam int FMT_LO = 26;
  localparam int CTRL_HI = 25;
  localparam int CTRL_LO = 21;
  localparam int SETC_BIT = 20;
  localparam logic [1:0] FMT_ALU = 2'b00;
  localparam logic [1:0] FMT_LS = 2'b01;
  localparam logic [1:0] FMT_BR = 2'b10;
  typedef enum logic {RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 synchronous FIFO with flush and occupancy count
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing credit-limited in-order imem reads, buffering words for decode,
// and discarding stale responses after a redirect.
module fetch_unit import pipeline_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [3:0]        out_condition,
  output logic [1:0]        out_format,
  output logic [4:0]        out_controls,
  output logic              out_set_condition
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc, tag_pc;
  logic [CW-1:0] inflight, fifo_count, drop, drop_n;
  logic [INSTR_W+ADDR_W-1:0] head;
  logic req_fire, rsp_live, out_fire, tag_empty, tag_full, instr_empty, instr_full;
  logic unused;
  assign unused = instr_full;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_live = imem_rsp_valid && state == RUN && !redirect_valid && !tag_empty;
  assign out_fire = out_valid && out_ready;
  assign imem_req_addr = pc;
  // Tag FIFO occupancy is exactly the number of live requests in flight
  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .rst(rst), .push(req_fire), .pop(rsp_live), .flush(redirect_valid),
    .din(pc), .dout(tag_pc), .count(inflight), .empty(tag_empty), .full(tag_full)
  );
  sync_fifo #(.WIDTH(INSTR_W + ADDR_W), .DEPTH(DEPTH)) u_instr (
    .clk(clk), .rst(rst), .push(rsp_live), .pop(out_fire), .flush(redirect_valid),
    .din({imem_rsp_data, tag_pc}), .dout(head), .count(fifo_count), .empty(instr_empty), .full(instr_full)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      drop <= '0;
      pc <= RESET_PC;
    end else begin
      state <= state_n;
      drop <= drop_n;
      pc <= redirect_valid ? redirect_pc : req_fire ? pc + ADDR_W'(PC_STEP) : pc;
    end
  end
  // Responses owed by the memory but no longer wanted
  always_comb begin
    drop_n = state == DRAIN ? drop : redirect_valid ? inflight + CW'(req_fire) : '0;
    drop_n = drop_n - CW'(imem_rsp_valid && (state == DRAIN || redirect_valid));
    state_n = ((state == DRAIN || redirect_valid) && drop_n != '0) ? DRAIN : RUN;
  end
  always_comb
    imem_req_valid = !rst && state == RUN && !redirect_valid && !tag_full &&
                     ({1'b0, inflight} + {1'b0, fifo_count} < (CW + 1)'(DEPTH));
  assign out_valid = !instr_empty;
  assign out_instr = head[ADDR_W +: INSTR_W];
  assign out_pc = head[ADDR_W-1:0];
  assign out_condition = out_instr[COND_HI:COND_LO];
  assign out_format = out_instr[FMT_HI:FMT_LO];
  assign out_controls = out_instr[CTRL_HI:CTRL_LO];
  assign out_set_condition = out_instr[SETC_BIT];
endmodule
